// File: rtl/instruction_store.sv
// Loadable instruction memory with a registered fetch port and a byte-serial
// valid/ready download port. Words arrive least-significant byte first; fetch
// is suppressed while a download is in progress.
module instruction_store #(
  parameter int unsigned             INSN_WIDTH   = 30,
  parameter int unsigned             ADDR_WIDTH   = 16,
  parameter int unsigned             DEPTH        = 256,
  parameter logic [INSN_WIDTH-1:0]   DEFAULT_INSN = INSN_WIDTH'(32'h000000AA),
  parameter string                   INIT_FILE    = ""
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] iFetchAddress,
  input  logic                  iFetchEnable,
  output logic [INSN_WIDTH-1:0] oInstruction,
  output logic                  oInstructionValid,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadWordCount,
  input  logic [7:0]            iLoadByte,
  input  logic                  iLoadByteValid,
  output logic                  oLoadByteReady,
  output logic                  oLoadBusy,
  output logic                  oLoadDone,
  output logic                  oLoadError
);

  localparam int unsigned BYTES  = (INSN_WIDTH + 7) / 8;
  localparam int unsigned ASM_W  = BYTES * 8;
  localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ASM_W-1:0]        asm_q, asm_d, asm_word;
  logic                    err_q, err_d;
  logic                    zdone_q, zdone_d;

  logic                    xfer;
  logic                    word_wr;
  logic                    last_word;
  logic                    fetch_in_range;
  logic [ADDR_WIDTH:0]     depth_ext;

  logic [INSN_WIDTH-1:0]   mem [DEPTH];

  assign depth_ext      = (ADDR_WIDTH + 1)'(DEPTH);
  assign xfer           = iLoadByteValid && oLoadByteReady;
  assign word_wr        = xfer && (idx_q == IDX_W'(BYTES - 1));
  assign last_word      = (waddr_q == count_q - 1'b1);
  assign fetch_in_range = ({1'b0, iFetchAddress} < depth_ext);

  // Current assembly register with the incoming byte merged at its lane, so the
  // final byte of a word can be written to memory on the edge that accepts it.
  always_comb begin
    asm_word = asm_q;
    asm_word[idx_q*8 +: 8] = iLoadByte;
  end

  // Download FSM next-state logic and bookkeeping counters.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    waddr_d = waddr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    err_d   = err_q;
    zdone_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iLoadStart) begin
          if (iLoadWordCount == '0) begin
            zdone_d = 1'b1;
          end else if ({1'b0, iLoadWordCount} > depth_ext) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            waddr_d = '0;
            idx_d   = '0;
            count_d = iLoadWordCount;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          asm_d = asm_word;
          if (word_wr) begin
            idx_d   = '0;
            waddr_d = waddr_q + 1'b1;
            if (last_word) begin
              state_d = StDone;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM and download state registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      count_q <= '0;
      waddr_q <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      zdone_q <= zdone_d;
    end
  end

  // Memory write of a completed word; bits above INSN_WIDTH are dropped.
  always_ff @(posedge Clock) begin
    if (word_wr) begin
      mem[waddr_q[MEM_AW-1:0]] <= asm_word[INSN_WIDTH-1:0];
    end
  end

  // Registered fetch port, only serviced while idle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oInstruction      <= DEFAULT_INSN;
      oInstructionValid <= 1'b0;
    end else if (state_q == StIdle && iFetchEnable) begin
      oInstruction      <= fetch_in_range ? mem[iFetchAddress[MEM_AW-1:0]] : DEFAULT_INSN;
      oInstructionValid <= 1'b1;
    end else begin
      oInstructionValid <= 1'b0;
    end
  end

  assign oLoadByteReady = (state_q == StLoad);
  assign oLoadBusy      = (state_q != StIdle);
  assign oLoadDone      = (state_q == StDone) || zdone_q;
  assign oLoadError     = err_q;

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store: reset, loads, range/default fetch,
// backpressure, reset abort, zero-count and overlapping starts.
module tb_instruction_store;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] iFetchAddress;
  logic        iFetchEnable;
  logic [29:0] oInstruction;
  logic        oInstructionValid;
  logic        iLoadStart;
  logic [15:0] iLoadWordCount;
  logic [7:0]  iLoadByte;
  logic        iLoadByteValid;
  logic        oLoadByteReady;
  logic        oLoadBusy;
  logic        oLoadDone;
  logic        oLoadError;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  instruction_store dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .iFetchAddress     (iFetchAddress),
    .iFetchEnable      (iFetchEnable),
    .oInstruction      (oInstruction),
    .oInstructionValid (oInstructionValid),
    .iLoadStart        (iLoadStart),
    .iLoadWordCount    (iLoadWordCount),
    .iLoadByte         (iLoadByte),
    .iLoadByteValid    (iLoadByteValid),
    .oLoadByteReady    (oLoadByteReady),
    .oLoadBusy         (oLoadBusy),
    .oLoadDone         (oLoadDone),
    .oLoadError        (oLoadError)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    iFetchAddress  = '0;
    iFetchEnable   = 1'b0;
    iLoadStart     = 1'b0;
    iLoadWordCount = '0;
    iLoadByte      = '0;
    iLoadByteValid = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [31:0] exp, input string tag);
    iFetchAddress = a;
    iFetchEnable  = 1'b1;
    tick();
    iFetchEnable  = 1'b0;
    check(tag, 32'(oInstruction), exp);
    check({tag, "_valid"}, 32'(oInstructionValid), 32'd1);
  endtask

  task automatic start(input logic [15:0] count);
    iLoadStart     = 1'b1;
    iLoadWordCount = count;
    tick();
    iLoadStart     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    iLoadByte      = b;
    iLoadByteValid = 1'b1;
    tick();
    iLoadByteValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] lb [8];
    logic [7:0] wb [4];
    logic [7:0] ob [4];

    lb = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h00, 8'h00, 8'hC0};
    wb = '{8'hF0, 8'hDE, 8'hBC, 8'h0A};
    ob = '{8'h78, 8'h56, 8'h34, 8'h12};

    // Reset held with random inputs.
    Reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      iFetchAddress  = 16'($urandom);
      iFetchEnable   = 1'($urandom);
      iLoadStart     = 1'($urandom);
      iLoadWordCount = 16'($urandom);
      iLoadByte      = 8'($urandom);
      iLoadByteValid = 1'($urandom);
      tick();
    end
    check("rst_insn",  32'(oInstruction), 32'h000000AA);
    check("rst_valid", 32'(oInstructionValid), 32'd0);
    check("rst_ready", 32'(oLoadByteReady), 32'd0);
    check("rst_busy",  32'(oLoadBusy), 32'd0);
    check("rst_done",  32'(oLoadDone), 32'd0);
    check("rst_err",   32'(oLoadError), 32'd0);
    idle_inputs();
    #2 Reset = 1'b1;
    tick();
    tick();
    check("post_rst_insn",  32'(oInstruction), 32'h000000AA);
    check("post_rst_valid", 32'(oInstructionValid), 32'd0);
    check("post_rst_busy",  32'(oLoadBusy), 32'd0);

    // Two-word load on consecutive cycles.
    start(16'd2);
    check("load2_ready", 32'(oLoadByteReady), 32'd1);
    check("load2_busy",  32'(oLoadBusy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      iLoadByte      = lb[i];
      iLoadByteValid = 1'b1;
      tick();
      if (i == 6) check("load2_done_early", 32'(oLoadDone), 32'd0);
    end
    iLoadByteValid = 1'b0;
    check("load2_done",       32'(oLoadDone), 32'd1);
    check("load2_done_ready", 32'(oLoadByteReady), 32'd0);
    check("load2_done_busy",  32'(oLoadBusy), 32'd1);
    tick();
    check("load2_done_clr", 32'(oLoadDone), 32'd0);
    check("load2_idle",     32'(oLoadBusy), 32'd0);
    fetch(16'd0, 32'h11223344, "mem0");
    fetch(16'd1, 32'h00000001, "mem1_trunc");
    tick();
    check("hold_valid", 32'(oInstructionValid), 32'd0);
    check("hold_insn",  32'(oInstruction), 32'h00000001);

    // Range, default word and rejected start.
    fetch(16'd300, 32'h000000AA, "oob_default");
    start(16'd257);
    check("big_err",  32'(oLoadError), 32'd1);
    check("big_busy", 32'(oLoadBusy), 32'd0);

    // Accepted start clears the error; load with gaps and fetch held high.
    start(16'd1);
    check("ok_err",  32'(oLoadError), 32'd0);
    check("ok_busy", 32'(oLoadBusy), 32'd1);
    iFetchEnable  = 1'b1;
    iFetchAddress = 16'd0;
    for (int i = 0; i < 8; i++) begin
      iLoadByteValid = (i % 2 == 0);
      iLoadByte      = (i % 2 == 0) ? wb[i/2] : 8'hFF;
      tick();
      check("bp_valid", 32'(oInstructionValid), 32'd0);
      check("bp_insn",  32'(oInstruction), 32'h000000AA);
      if (i == 6) check("bp_done", 32'(oLoadDone), 32'd1);
    end
    iLoadByteValid = 1'b0;
    tick();
    iFetchEnable = 1'b0;
    check("bp_mem0",       32'(oInstruction), 32'h0ABCDEF0);
    check("bp_mem0_valid", 32'(oInstructionValid), 32'd1);
    fetch(16'd1, 32'h00000001, "bp_mem1");

    // Reset after one full word plus two bytes of the second.
    start(16'd2);
    send_byte(8'h04);
    send_byte(8'h03);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #1 Reset = 1'b0;
    #1;
    check("abort_busy",  32'(oLoadBusy), 32'd0);
    check("abort_ready", 32'(oLoadByteReady), 32'd0);
    check("abort_insn",  32'(oInstruction), 32'h000000AA);
    #1 Reset = 1'b1;
    tick();
    check("abort_idle", 32'(oLoadBusy), 32'd0);
    fetch(16'd0, 32'h01020304, "abort_mem0");
    fetch(16'd1, 32'h00000001, "abort_mem1_old");

    // Zero-count start.
    start(16'd0);
    check("zero_done", 32'(oLoadDone), 32'd1);
    check("zero_busy", 32'(oLoadBusy), 32'd0);
    tick();
    check("zero_done_clr", 32'(oLoadDone), 32'd0);
    fetch(16'd0, 32'h01020304, "zero_mem0");

    // Start and fetch together: fetch sees pre-load contents.
    iFetchEnable   = 1'b1;
    iFetchAddress  = 16'd0;
    iLoadStart     = 1'b1;
    iLoadWordCount = 16'd1;
    tick();
    iLoadStart   = 1'b0;
    iFetchEnable = 1'b0;
    check("both_insn",  32'(oInstruction), 32'h01020304);
    check("both_valid", 32'(oInstructionValid), 32'd1);
    check("both_busy",  32'(oLoadBusy), 32'd1);

    // A start during the load must not change the latched count.
    for (int i = 0; i < 4; i++) begin
      iLoadStart     = (i == 1);
      iLoadWordCount = 16'd5;
      send_byte(ob[i]);
    end
    iLoadStart = 1'b0;
    check("overlap_done", 32'(oLoadDone), 32'd1);
    tick();
    check("overlap_idle", 32'(oLoadBusy), 32'd0);
    fetch(16'd0, 32'h12345678, "overlap_mem0");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
